// File: rtl/pll_rst_seq.sv
// PLL power-up / reset sequencer: power-down, reset, lock qualification,
// lock-loss recovery, timeout fault and output-divider reconfiguration.
module pll_rst_seq #(
    parameter int unsigned PWD_CYCLES   = 2,
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       start,
    input  logic       cfg_valid,
    input  logic [9:0] cfg_odiv,
    output logic       cfg_ready,
    output logic       pll_pwd,
    output logic       pll_rst,
    output logic [9:0] dyn_odiv0,
    output logic       locked,
    output logic       timeout_err,
    output logic [2:0] lock_loss_cnt,
    output logic       busy
);

    localparam int unsigned ODIV_W  = 10;
    localparam int unsigned LLC_W   = 3;
    localparam int unsigned MAX_PR  = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_PR > LOCK_STABLE) ? MAX_PR : LOCK_STABLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TO_W    = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  PWD_LAST = CNT_W'(PWD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ODIV_W-1:0] ODIV_RST = ODIV_W'(100);
    localparam logic [LLC_W-1:0]  LLC_MAX  = '1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PWD    = 3'd1;
    localparam logic [2:0] S_RST    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STABLE = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [TO_W-1:0]  tcnt, tcnt_nxt;
    logic             lock_meta, lock_s;
    logic             cfg_take, loss_evt;

    // Next-state logic; one phase counter for PWD/RST/STABLE, one timeout counter for WAIT/STABLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tcnt_nxt  = tcnt;
        loss_evt  = 1'b0;
        cfg_ready = (state == S_RUN) & lock_s & ~start;
        cfg_take  = cfg_valid & cfg_ready;
        case (state)
            S_IDLE: begin
                state_nxt = S_PWD;
                cnt_nxt   = '0;
            end
            S_PWD: begin
                if (cnt == PWD_LAST) begin
                    state_nxt = S_RST;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                    tcnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (tcnt == TO_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_STABLE: begin
                if (tcnt == TO_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                    if (!lock_s) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                // lock loss beats start beats cfg; losers are dropped
                if (!lock_s) begin
                    loss_evt  = 1'b1;
                    state_nxt = S_RST;
                    cnt_nxt   = '0;
                end else if (start) begin
                    state_nxt = S_PWD;
                    cnt_nxt   = '0;
                end else if (cfg_take) begin
                    state_nxt = S_RST;
                    cnt_nxt   = '0;
                end
            end
            S_FAULT: begin
                if (start) begin
                    state_nxt = S_PWD;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                tcnt_nxt  = '0;
            end
        endcase
    end

    // State, synchroniser and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            tcnt          <= '0;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            pll_pwd       <= 1'b0;
            pll_rst       <= 1'b1;
            dyn_odiv0     <= ODIV_RST;
            locked        <= 1'b0;
            timeout_err   <= 1'b0;
            lock_loss_cnt <= '0;
            busy          <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            tcnt        <= tcnt_nxt;
            lock_meta   <= pll_lock;
            lock_s      <= lock_meta;
            pll_pwd     <= (state_nxt == S_PWD);
            pll_rst     <= (state_nxt inside {S_IDLE, S_PWD, S_RST, S_FAULT});
            locked      <= (state_nxt == S_RUN);
            timeout_err <= (state_nxt == S_FAULT);
            busy        <= !(state_nxt inside {S_RUN, S_FAULT});
            if (loss_evt && (lock_loss_cnt != LLC_MAX)) begin
                lock_loss_cnt <= lock_loss_cnt + LLC_W'(1);
            end
            if (cfg_take) begin
                dyn_odiv0 <= (cfg_odiv == '0) ? ODIV_W'(1) : cfg_odiv;
            end
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: phase/elapsed-time reference model, per-cycle compare,
// directed scenarios with literal cycle pins, then randomized traffic.
module tb_pll_rst_seq;

    localparam int TB_PWD  = 2;
    localparam int TB_RST  = 2;
    localparam int TB_TO   = 100;
    localparam int TB_STB  = 16;

    localparam int P_IDLE  = 0;
    localparam int P_PWD   = 1;
    localparam int P_RST   = 2;
    localparam int P_WAIT  = 3;
    localparam int P_STAB  = 4;
    localparam int P_RUN   = 5;
    localparam int P_FAULT = 6;

    logic       clk_tb = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [9:0] cfg_odiv = 10'd0;
    logic       cfg_ready;
    logic       pll_pwd;
    logic       pll_rst;
    logic [9:0] dyn_odiv0;
    logic       locked;
    logic       timeout_err;
    logic [2:0] lock_loss_cnt;
    logic       busy;

    pll_rst_seq #(
        .PWD_CYCLES  (TB_PWD),
        .RST_CYCLES  (TB_RST),
        .LOCK_TIMEOUT(TB_TO),
        .LOCK_STABLE (TB_STB)
    ) dut (
        .clk          (clk_tb),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .start        (start),
        .cfg_valid    (cfg_valid),
        .cfg_odiv     (cfg_odiv),
        .cfg_ready    (cfg_ready),
        .pll_pwd      (pll_pwd),
        .pll_rst      (pll_rst),
        .dyn_odiv0    (dyn_odiv0),
        .locked       (locked),
        .timeout_err  (timeout_err),
        .lock_loss_cnt(lock_loss_cnt),
        .busy         (busy)
    );

    always #5 clk_tb = ~clk_tb;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: current phase, cycles spent in it, cycles since the lock wait began
    int  m_ph = P_IDLE;
    int  m_t = 0;
    int  m_wt = 0;
    int  m_loss = 0;
    bit  m_terr = 1'b0;
    int  m_odiv = 100;
    int  cyc = 0;
    bit  lock_hist[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    initial begin : model
        bit ls;
        int nph;
        forever begin
            @(posedge clk_tb);
            if (rst) begin
                m_ph = P_IDLE; m_t = 0; m_wt = 0; m_loss = 0; m_terr = 1'b0; m_odiv = 100;
                lock_hist = '{1'b0, 1'b0};
                cyc = 0;
            end else begin
                ls = lock_hist[0];
                void'(lock_hist.pop_front());
                lock_hist.push_back(pll_lock);
                nph = m_ph;
                case (m_ph)
                    P_IDLE:  nph = P_PWD;
                    P_PWD:   if (m_t + 1 >= TB_PWD) nph = P_RST;
                    P_RST:   if (m_t + 1 >= TB_RST) begin nph = P_WAIT; m_wt = 0; end
                    P_WAIT, P_STAB: begin
                        m_wt++;
                        if (m_wt >= TB_TO) begin nph = P_FAULT; m_terr = 1'b1; end
                        else if (m_ph == P_WAIT && ls) nph = P_STAB;
                        else if (m_ph == P_STAB && !ls) nph = P_WAIT;
                        else if (m_ph == P_STAB && m_t + 1 >= TB_STB) nph = P_RUN;
                    end
                    P_RUN: begin
                        if (!ls) begin
                            if (m_loss < 7) m_loss++;
                            nph = P_RST;
                        end else if (start) begin
                            nph = P_PWD;
                        end else if (cfg_valid) begin
                            m_odiv = (cfg_odiv == 10'd0) ? 1 : int'(cfg_odiv);
                            nph = P_RST;
                        end
                    end
                    P_FAULT: if (start) begin nph = P_PWD; m_terr = 1'b0; end
                    default: nph = P_IDLE;
                endcase
                if (nph != m_ph) m_t = 0; else m_t++;
                m_ph = nph;
                cyc++;
            end
        end
    end

    // Every cycle: all outputs against the model
    initial begin : compare
        forever begin
            @(negedge clk_tb);
            if (chk_en) begin
                chk("pll_pwd", int'(pll_pwd), int'(m_ph == P_PWD));
                chk("pll_rst", int'(pll_rst),
                    int'(m_ph == P_IDLE || m_ph == P_PWD || m_ph == P_RST || m_ph == P_FAULT));
                chk("locked", int'(locked), int'(m_ph == P_RUN));
                chk("busy", int'(busy), int'(m_ph != P_RUN && m_ph != P_FAULT));
                chk("timeout_err", int'(timeout_err), int'(m_terr));
                chk("dyn_odiv0", int'(dyn_odiv0), m_odiv);
                chk("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
                chk("cfg_ready", int'(cfg_ready), int'(m_ph == P_RUN && lock_hist[0] && !start));
            end
        end
    end

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_tb);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic at(input int k);
        run_to(k);
        smp();
    endtask

    task automatic wait_run(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (m_ph == P_RUN) break;
            tick();
        end
        if (i == budget) chk("wait_run_timeout", 0, 1);
    endtask

    initial begin : stim
        int d;
        do_reset();
        chk_en = 1'b1;

        // Nominal power-up
        pll_lock = 1'b0;
        at(0);
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_pll_pwd", int'(pll_pwd), 0);
        chk("rst_odiv", int'(dyn_odiv0), 100);
        chk("rst_locked", int'(locked), 0);
        at(1);  chk("nom_pwd1", int'(pll_pwd), 1);
        at(2);  chk("nom_pwd2", int'(pll_pwd), 1);
        at(3);  chk("nom_pwd3", int'(pll_pwd), 0); chk("nom_rst3", int'(pll_rst), 1);
        at(4);  chk("nom_rst4", int'(pll_rst), 1);
        at(5);  chk("nom_rst5", int'(pll_rst), 0);
        run_to(10); pll_lock = 1'b1;
        at(28); chk("nom_lock28", int'(locked), 0);
        at(29); chk("nom_lock29", int'(locked), 1); chk("nom_busy29", int'(busy), 0);

        // Glitch at the 8th STABLE cycle: fresh 16-cycle qualification
        do_reset(); pll_lock = 1'b0;
        run_to(10); pll_lock = 1'b1;
        run_to(20); pll_lock = 1'b0;
        run_to(21); pll_lock = 1'b1;
        at(29); chk("gl_lock29", int'(locked), 0);
        at(39); chk("gl_lock39", int'(locked), 0);
        at(40); chk("gl_lock40", int'(locked), 1);

        // Timeout with a start ignored mid-wait, then restart from FAULT
        do_reset(); pll_lock = 1'b0;
        run_to(50); start = 1'b1; tick(); start = 1'b0;
        at(104); chk("to_err104", int'(timeout_err), 0); chk("to_rst104", int'(pll_rst), 0);
        at(105); chk("to_err105", int'(timeout_err), 1); chk("to_rst105", int'(pll_rst), 1);
        run_to(110); start = 1'b1;
        smp(); chk("to_cfgrdy", int'(cfg_ready), 0);
        tick(); start = 1'b0;
        smp(); chk("to_pwd111", int'(pll_pwd), 1); chk("to_err111", int'(timeout_err), 0);
        tick(); smp(); chk("to_pwd112", int'(pll_pwd), 1);
        tick(); smp(); chk("to_pwd113", int'(pll_pwd), 0);
        pll_lock = 1'b1;
        wait_run(200);

        // Nine lock losses in RUN
        for (int n = 0; n < 9; n++) begin
            wait_run(200);
            repeat ($urandom_range(0, 5)) tick();
            pll_lock = 1'b0;
            d = $urandom_range(1, 3);
            repeat (d) tick();
            pll_lock = 1'b1;
            repeat (3) tick();
        end
        wait_run(200);
        smp();
        chk("loss_sat", int'(lock_loss_cnt), 7);
        chk("loss_locked", int'(locked), 1);

        // Reconfiguration
        tick();
        cfg_odiv = 10'd200; cfg_valid = 1'b1;
        smp(); chk("cfg_ready_run", int'(cfg_ready), 1);
        tick(); cfg_valid = 1'b0;
        smp(); chk("cfg_odiv200", int'(dyn_odiv0), 200); chk("cfg_rst1", int'(pll_rst), 1);
        tick(); smp(); chk("cfg_rst2", int'(pll_rst), 1);
        tick(); smp(); chk("cfg_rst3", int'(pll_rst), 0);
        wait_run(200);
        cfg_odiv = 10'd0; cfg_valid = 1'b1;
        tick(); cfg_valid = 1'b0;
        smp(); chk("cfg_clamp", int'(dyn_odiv0), 1);
        wait_run(200);

        // start and cfg together: start wins, cfg dropped
        start = 1'b1; cfg_valid = 1'b1; cfg_odiv = 10'd300;
        smp(); chk("col_ready", int'(cfg_ready), 0);
        tick(); start = 1'b0; cfg_valid = 1'b0;
        smp(); chk("col_odiv", int'(dyn_odiv0), 1); chk("col_pwd", int'(pll_pwd), 1);

        // rst while in STABLE
        do_reset(); pll_lock = 1'b1;
        run_to(10); rst = 1'b1;
        tick();
        smp();
        chk("rs_pwd", int'(pll_pwd), 0); chk("rs_rst", int'(pll_rst), 1);
        chk("rs_odiv", int'(dyn_odiv0), 100); chk("rs_locked", int'(locked), 0);
        chk("rs_err", int'(timeout_err), 0); chk("rs_loss", int'(lock_loss_cnt), 0);
        rst = 1'b0;
        at(1); chk("rs_restart_pwd", int'(pll_pwd), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 19) == 0) pll_lock = ~pll_lock;
            start     = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_odiv  = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            rst       = ($urandom_range(0, 499) == 0);
        end
        tick();
        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter PWD_CYCLES, default 2: number of cycles pll_pwd is held high during power-up.
REQ-002 Parameter RST_CYCLES, default 2: number of cycles pll_rst is held high after pll_pwd falls.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: maximum WAIT_LOCK+STABLE cycles before a fault is declared.
REQ-004 Parameter LOCK_STABLE, default 16: number of consecutive synchronised-lock cycles required to declare lock.
REQ-005 Port clk, input, 1: single clock domain.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port pll_lock, input, 1: asynchronous PLL lock indicator.
REQ-008 Port start, input, 1: single-cycle request to re-run the full power-up sequence.
REQ-009 Port cfg_valid, input, 1: output-divider update request.
REQ-010 Port cfg_odiv, input, 10: new output-divider value.
REQ-011 Port cfg_ready, output, 1: an update is accepted this cycle when cfg_valid is also high.
REQ-012 Port pll_pwd, output, 1: PLL power-down, active-high.
REQ-013 Port pll_rst, output, 1: PLL reset, active-high.
REQ-014 Port dyn_odiv0, output, 10: divider value driven to the PLL.
REQ-015 Port locked, output, 1: qualified lock.
REQ-016 Port timeout_err, output, 1: sticky lock-timeout flag.
REQ-017 Port lock_loss_cnt, output, 3: count of lock-loss events, saturating.
REQ-018 Port busy, output, 1: high in every state except RUN and FAULT.

Function
REQ-019 pll_lock SHALL pass through a 2-flop synchroniser (lock_s); all lock decisions SHALL use lock_s, giving 2 cycles of latency.
REQ-020 The FSM states SHALL be IDLE, PWD, RST, WAIT_LOCK, STABLE, RUN and FAULT; a single cycle counter serves PWD, RST and STABLE; a separate timeout counter serves WAIT_LOCK and STABLE.
REQ-021 IDLE SHALL drive pll_pwd=0 and pll_rst=1, and SHALL go to PWD unconditionally on the next cycle.
REQ-022 PWD SHALL drive pll_pwd=1 and pll_rst=1 for exactly PWD_CYCLES cycles, then go to RST.
REQ-023 RST SHALL drive pll_pwd=0 and pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with the timeout counter cleared.
REQ-024 WAIT_LOCK SHALL drive pll_rst=0: lock_s=1 goes to STABLE; timeout count reaching LOCK_TIMEOUT goes to FAULT.
REQ-025 STABLE SHALL count consecutive lock_s=1 cycles: reaching LOCK_STABLE goes to RUN with locked=1 on entry; lock_s=0 returns to WAIT_LOCK without clearing the timeout counter; timeout still applies.
REQ-026 RUN SHALL hold locked=1; lock_s=0 SHALL clear locked, increment lock_loss_cnt (saturating at 7) and go to RST in the same cycle.
REQ-027 FAULT SHALL set timeout_err=1 and drive pll_rst=1; it SHALL stay in FAULT until start.
REQ-028 start SHALL be honoured only in RUN or FAULT: it goes to PWD, clears locked and clears timeout_err; start in any other state SHALL be ignored.
REQ-029 cfg_ready SHALL equal (state==RUN) & lock_s & ~start, combinationally.
REQ-030 On cfg_valid&cfg_ready, dyn_odiv0 SHALL load cfg_odiv on the next edge (value 0 clamped to 1), locked SHALL clear, and the FSM SHALL go to RST.
REQ-031 Priority within RUN SHALL be: lock loss, then start, then cfg; a lower-priority request in the same cycle SHALL be dropped, not queued.

Reset
REQ-032 rst, sampled at a clock edge, SHALL force state=IDLE, pll_pwd=0, pll_rst=1, dyn_odiv0=10'd100, locked=0, timeout_err=0, lock_loss_cnt=0, both counters 0 and the synchroniser 0.
REQ-033 rst asserted mid-sequence, in any state, SHALL abort the sequence; the full sequence SHALL restart from IDLE after release.

Verification
REQ-034 Nominal: defaults, rst released at cycle 0, pll_lock=1 from cycle 10 -> pll_pwd high in cycles 1-2, pll_rst high in cycles 0-4, locked=1 from cycle 14+LOCK_STABLE±1, dyn_odiv0=100.
REQ-035 Timeout: LOCK_TIMEOUT=100, pll_lock held 0 -> timeout_err=1 and pll_rst=1 after 100 WAIT_LOCK cycles; start -> pll_pwd pulses again and timeout_err clears.
REQ-036 Glitch: pll_lock drops for 1 cycle at the 8th STABLE cycle -> locked stays 0; lock is re-qualified over a fresh 16 cycles.
REQ-037 Loss: 9 lock drops while in RUN -> 9 re-sequences, lock_loss_cnt=7 (saturated), locked=1 after the final relock.
REQ-038 Reconfig: cfg_odiv=200 with cfg_valid in RUN -> dyn_odiv0=200, pll_rst pulses for 2 cycles, locked relocks; cfg_odiv=0 -> dyn_odiv0=1.
REQ-039 Collisions: start and cfg_valid high together -> cfg_ready=0 and dyn_odiv0 unchanged; rst asserted in STABLE -> all outputs at their REQ-032 values on the next cycle.
